// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: scan states,
// active-low segment table and the "all off" constants.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Indexed by nibble value; leftmost entry is 4'hF, segments are {g,f,e,d,c,b,a}.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] anode_for(input logic [1:0] sel, input logic [3:0] mask);
    logic [3:0] onehot;
    onehot = 4'b0001 << sel;
    return mask[sel] ? AN_OFF : ~onehot;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-division scan controller with dead-time blanking between
// digit slots; every output is registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig_in,
  input  logic [3:0] dp_in,
  input  logic [3:0] blank_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       scan_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(TICK_DIV - 1);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sel_next;
  logic [3:0]       an_next;
  logic [6:0]       seg_next, seg_code;
  logic             dp_next, done_next;

  hex7seg u_dec (
    .hex (dig_in),
    .seg (seg_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 2'd0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sel       <= sel_next;
      an        <= an_next;
      seg       <= seg_next;
      dp        <= dp_next;
      scan_done <= done_next;
    end
  end

  // The slot counter runs 0..TICK_DIV-1 across BLANK then SHOW, so one slot
  // is always exactly TICK_DIV cycles regardless of masking.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel;
    an_next    = AN_OFF;
    seg_next   = seg;
    dp_next    = dp;
    done_next  = 1'b0;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
      sel_next   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_next = BLANK;
          cnt_next   = '0;
          sel_next   = 2'd0;
        end
        BLANK: begin
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_BLANK) begin
            state_next = SHOW;
            seg_next   = seg_code;
            dp_next    = ~dp_in[sel];
            an_next    = anode_for(sel, blank_mask);
          end
        end
        SHOW: begin
          if (cnt == LAST_SLOT) begin
            state_next = BLANK;
            cnt_next   = '0;
            sel_next   = sel + 2'd1;
            done_next  = (sel == 2'd3);
          end else begin
            cnt_next = cnt + 1'b1;
            an_next  = anode_for(sel, blank_mask);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          sel_next   = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a slot-time model checked every
// cycle plus directed scenarios with hand-derived expectations.
module tb_seg_scan_ctrl;

  localparam int TICK_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] dig_in;
  logic [3:0] dp_in = 4'b0000;
  logic [3:0] blank_mask = 4'b0000;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       scan_done;

  logic [3:0] digits [4];
  int checks = 0;
  int failures = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dig_in     (dig_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  // The board's nibble mux.
  assign dig_in = digits[sel];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                                input logic [3:0] d3, input logic [3:0] dpv, input logic [3:0] mask);
    digits[0] = d0;
    digits[1] = d1;
    digits[2] = d2;
    digits[3] = d3;
    dp_in = dpv;
    blank_mask = mask;
  endtask

  task automatic wait_an(input logic [3:0] val, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (an === val) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: timeout got an=%h expected %h", name, an, val);
    end
  endtask

  // Model: p counts edges since the scan started; slot, phase and frame
  // position follow directly from p.
  bit         m_active = 1'b0;
  int         m_p = 0;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;
  logic [3:0] m_mask = 4'b0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_p      <= 0;
      m_seg    <= 7'h7F;
      m_dp     <= 1'b1;
      m_mask   <= 4'b0000;
    end else begin
      m_mask <= blank_mask;
      if (!en) begin
        m_active <= 1'b0;
        m_p      <= 0;
      end else if (!m_active) begin
        m_active <= 1'b1;
        m_p      <= 0;
      end else begin
        m_p <= m_p + 1;
        if ((m_p + 1) % TICK_DIV == BLANK_CYC) begin
          m_seg <= seg_ref[digits[(m_p / TICK_DIV) % 4]];
          m_dp  <= ~dp_in[(m_p / TICK_DIV) % 4];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int         ph;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic [3:0] onehot;
    logic       e_done;
    e_sel  = m_active ? 2'((m_p / TICK_DIV) % 4) : 2'd0;
    ph     = m_p % TICK_DIV;
    onehot = 4'b0001 << e_sel;
    e_an   = (m_active && ph >= BLANK_CYC && !m_mask[e_sel]) ? ~onehot : 4'hF;
    e_done = m_active && m_p > 0 && (m_p % (4 * TICK_DIV)) == 0;
    check_output("model_sel", 8'(sel), 8'(e_sel));
    check_output("model_an", 8'(an), 8'(e_an));
    check_output("model_seg", 8'(seg), 8'(m_seg));
    check_output("model_dp", 8'(dp), 8'(m_dp));
    check_output("model_done", 8'(scan_done), 8'(e_done));
  end

  int  done_cnt;
  bit  seen_b;

  initial begin
    apply_stimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    check_output("reset_an", 8'(an), 8'hF);
    check_output("reset_seg", 8'(seg), 8'h7F);
    check_output("reset_sel", 8'(sel), 8'h0);
    check_output("reset_dp", 8'(dp), 8'h1);
    check_output("reset_done", 8'(scan_done), 8'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 en = 1'b1;

    // Scan of digits 1,2,3,4 with hand-derived anode/segment timeline.
    done_cnt = 0;
    for (int idx = 0; idx <= 64; idx++) begin
      @(negedge clk);
      if (idx >= 33 && scan_done) done_cnt++;
      case (idx)
        0, 2, 9, 10: check_output("scan_an_blank", 8'(an), 8'hF);
        3: begin
          check_output("scan_an_d0", 8'(an), 8'hE);
          check_output("scan_seg_d0", 8'(seg), 8'h79);
        end
        8: check_output("scan_an_d0_last", 8'(an), 8'hE);
        11: begin
          check_output("scan_an_d1", 8'(an), 8'hD);
          check_output("scan_seg_d1", 8'(seg), 8'h24);
        end
        19: begin
          check_output("scan_an_d2", 8'(an), 8'hB);
          check_output("scan_seg_d2", 8'(seg), 8'h30);
        end
        25: check_output("scan_done_early", 8'(scan_done), 8'h0);
        27: begin
          check_output("scan_an_d3", 8'(an), 8'h7);
          check_output("scan_seg_d3", 8'(seg), 8'h19);
        end
        33: begin
          check_output("wrap_done", 8'(scan_done), 8'h1);
          check_output("wrap_sel", 8'(sel), 8'h0);
          check_output("wrap_an", 8'(an), 8'hF);
        end
        default: ;
      endcase
    end
    check_output("done_per_frame", 8'(done_cnt), 8'd1);

    // Digit 2 masked: its anode must never be driven.
    @(posedge clk); #2 apply_stimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 4'b0100);
    seen_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === 4'hB) seen_b = 1'b1;
    end
    check_output("mask_no_b", 8'(seen_b), 8'h0);

    // Decimal point on digit 0 showing 'A'.
    @(posedge clk); #2 apply_stimulus(4'hA, 4'h2, 4'h3, 4'h4, 4'b0001, 4'b0000);
    wait_an(4'hF, "dp_sync");
    wait_an(4'hE, "dp_wait_d0");
    check_output("dp_seg_a", 8'(seg), 8'h08);
    check_output("dp_d0_on", 8'(dp), 8'h0);
    wait_an(4'hD, "dp_wait_d1");
    check_output("dp_d1_off", 8'(dp), 8'h1);

    // Drop en in the third SHOW cycle of digit 2.
    wait_an(4'hF, "drop_sync");
    wait_an(4'hB, "drop_wait_d2");
    @(posedge clk); #2;
    @(posedge clk); #2 en = 1'b0;
    @(negedge clk);
    check_output("drop_still_b", 8'(an), 8'hB);
    @(negedge clk);
    check_output("drop_an", 8'(an), 8'hF);
    check_output("drop_sel", 8'(sel), 8'h0);
    @(posedge clk); #2 en = 1'b1;
    for (int idx = 0; idx <= 3; idx++) begin
      @(negedge clk);
      if (idx < 3) check_output("restart_blank", 8'(an), 8'hF);
      else check_output("restart_d0", 8'(an), 8'hE);
    end

    // Asynchronous reset between edges during digit 1 SHOW.
    wait_an(4'hD, "rst_wait_d1");
    #1 rst = 1'b1;
    #1;
    check_output("async_an", 8'(an), 8'hF);
    check_output("async_seg", 8'(seg), 8'h7F);
    check_output("async_sel", 8'(sel), 8'h0);
    @(posedge clk); #2 rst = 1'b0;
    for (int idx = 0; idx <= 3; idx++) begin
      @(negedge clk);
      if (idx < 3) check_output("post_rst_blank", 8'(an), 8'hF);
      else check_output("post_rst_d0", 8'(an), 8'hE);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
